// File: rtl/wb_master_arbiter.sv
// wb_master_arbiter: shares one Wishbone master port among NUM_CH requesters.
// Arbitration is fixed priority (lowest index wins) or round-robin. The winner's
// virtual address is translated by the MMU in the grant cycle. Each transaction
// finishes with a one-cycle, one-hot ack or err pulse on the granted channel.
// A built-in bus timeout aborts a transaction that gets no slave response.
// The reset input rst is asynchronous and active-low.
module wb_master_arbiter #(
  parameter int NUM_CH  = 2,
  parameter int DW      = 32,
  parameter int AW      = 32,
  parameter int RR_MODE = 0,
  parameter int TIMEOUT = 255
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_CH-1:0]            ch_req_i,
  input  logic [NUM_CH-1:0]            ch_we_i,
  input  logic [NUM_CH-1:0]            ch_cancel_i,
  input  logic [NUM_CH*AW-1:0]         ch_addr_i,
  input  logic [NUM_CH*DW-1:0]         ch_wdata_i,
  input  logic [NUM_CH*(DW/8)-1:0]     ch_sel_i,
  output logic [DW-1:0]                ch_rdata_o,
  output logic [NUM_CH-1:0]            ch_ack_o,
  output logic [NUM_CH-1:0]            ch_err_o,
  output logic                         xlat_req_o,
  output logic                         xlat_we_o,
  output logic [AW-1:0]                xlat_vaddr_o,
  input  logic [AW-1:0]                xlat_paddr_i,
  input  logic                         xlat_fault_i,
  output logic                         wb_cyc_o,
  output logic                         wb_stb_o,
  output logic                         wb_we_o,
  output logic [AW-1:0]                wb_adr_o,
  output logic [DW-1:0]                wb_dat_o,
  output logic [(DW/8)-1:0]            wb_sel_o,
  input  logic [DW-1:0]                wb_dat_i,
  input  logic                         wb_ack_i,
  input  logic                         wb_err_i
);

  localparam int SELW = DW / 8;
  localparam int GW   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  // Last timer value before the transaction is aborted.
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Registered state
  state_e            state_q,      state_d;
  logic [GW-1:0]     last_grant_q, last_grant_d;
  logic [GW-1:0]     grant_q,      grant_d;
  logic [15:0]       timer_q,      timer_d;
  logic              cancel_q,     cancel_d;
  logic              resp_err_q,   resp_err_d;
  logic              wb_cyc_q,     wb_cyc_d;
  logic              wb_stb_q,     wb_stb_d;
  logic              wb_we_q,      wb_we_d;
  logic [AW-1:0]     wb_adr_q,     wb_adr_d;
  logic [DW-1:0]     wb_dat_q,     wb_dat_d;
  logic [SELW-1:0]   wb_sel_q,     wb_sel_d;
  logic [DW-1:0]     rdata_q,      rdata_d;

  // Arbitration results
  logic [NUM_CH-1:0] cand_s;
  logic              win_valid_s;
  logic [GW-1:0]     win_idx_s;
  logic              win_we_s;
  logic [AW-1:0]     win_addr_s;
  logic [DW-1:0]     win_wdata_s;
  logic [SELW-1:0]   win_sel_s;

  // Response shaping
  logic              suppress_s;
  logic [NUM_CH-1:0] grant_oh_s;

  // Pick the winning channel among live (requesting, not cancelled) channels.
  always_comb begin
    cand_s      = ch_req_i & ~ch_cancel_i;
    win_valid_s = 1'b0;
    win_idx_s   = '0;
    if (RR_MODE != 0) begin
      // Round-robin: first candidate above last_grant, then wrap to the bottom.
      for (int j = 0; j < NUM_CH; j++) begin
        if (!win_valid_s && cand_s[j] && (j > int'(last_grant_q))) begin
          win_valid_s = 1'b1;
          win_idx_s   = GW'(j);
        end
      end
      for (int j = 0; j < NUM_CH; j++) begin
        if (!win_valid_s && cand_s[j] && (j <= int'(last_grant_q))) begin
          win_valid_s = 1'b1;
          win_idx_s   = GW'(j);
        end
      end
    end else begin
      for (int j = 0; j < NUM_CH; j++) begin
        if (!win_valid_s && cand_s[j]) begin
          win_valid_s = 1'b1;
          win_idx_s   = GW'(j);
        end
      end
    end
  end

  // Select the winner's request fields out of the packed channel buses.
  always_comb begin
    win_we_s    = 1'b0;
    win_addr_s  = '0;
    win_wdata_s = '0;
    win_sel_s   = '0;
    for (int j = 0; j < NUM_CH; j++) begin
      if (GW'(j) == win_idx_s) begin
        win_we_s    = ch_we_i[j];
        win_addr_s  = ch_addr_i[j*AW +: AW];
        win_wdata_s = ch_wdata_i[j*DW +: DW];
        win_sel_s   = ch_sel_i[j*SELW +: SELW];
      end
    end
  end

  // Translation request is purely combinational and only raised in IDLE.
  always_comb begin
    xlat_req_o   = (state_q == ST_IDLE) && win_valid_s;
    xlat_we_o    = xlat_req_o ? win_we_s : 1'b0;
    xlat_vaddr_o = xlat_req_o ? win_addr_s : '0;
  end

  // One-hot response pulse, dropped if the channel cancelled during or at RESP.
  always_comb begin
    grant_oh_s = NUM_CH'(1) << grant_q;
    suppress_s = cancel_q | ch_cancel_i[grant_q];
    if ((state_q == ST_RESP) && !suppress_s) begin
      ch_ack_o = resp_err_q ? '0 : grant_oh_s;
      ch_err_o = resp_err_q ? grant_oh_s : '0;
    end else begin
      ch_ack_o = '0;
      ch_err_o = '0;
    end
  end

  // Next-state and next-output computation for the IDLE/BUS/RESP sequencer.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    timer_d      = timer_q;
    cancel_d     = cancel_q;
    resp_err_d   = resp_err_q;
    wb_cyc_d     = wb_cyc_q;
    wb_stb_d     = wb_stb_q;
    wb_we_d      = wb_we_q;
    wb_adr_d     = wb_adr_q;
    wb_dat_d     = wb_dat_q;
    wb_sel_d     = wb_sel_q;
    rdata_d      = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (win_valid_s) begin
          // Faulted grants still advance last_grant so round-robin moves on.
          last_grant_d = win_idx_s;
          grant_d      = win_idx_s;
          cancel_d     = 1'b0;
          if (xlat_fault_i) begin
            resp_err_d = 1'b1;
            state_d    = ST_RESP;
          end else begin
            wb_cyc_d   = 1'b1;
            wb_stb_d   = 1'b1;
            wb_we_d    = win_we_s;
            wb_adr_d   = xlat_paddr_i;
            wb_dat_d   = win_wdata_s;
            wb_sel_d   = win_sel_s;
            timer_d    = 16'd0;
            state_d    = ST_BUS;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUS: begin
        cancel_d = cancel_q | ch_cancel_i[grant_q];
        if (wb_err_i) begin
          rdata_d    = '0;
          resp_err_d = 1'b1;
          wb_cyc_d   = 1'b0;
          wb_stb_d   = 1'b0;
          wb_we_d    = 1'b0;
          state_d    = ST_RESP;
        end else if (wb_ack_i) begin
          rdata_d    = wb_we_q ? '0 : wb_dat_i;
          resp_err_d = 1'b0;
          wb_cyc_d   = 1'b0;
          wb_stb_d   = 1'b0;
          wb_we_d    = 1'b0;
          state_d    = ST_RESP;
        end else if (timer_q == TMO_LAST) begin
          resp_err_d = 1'b1;
          wb_cyc_d   = 1'b0;
          wb_stb_d   = 1'b0;
          wb_we_d    = 1'b0;
          state_d    = ST_RESP;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d  = ST_IDLE;
        wb_cyc_d = 1'b0;
        wb_stb_d = 1'b0;
        wb_we_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset drops the bus cycle immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      last_grant_q <= GW'(NUM_CH - 1);
      grant_q      <= '0;
      timer_q      <= 16'd0;
      cancel_q     <= 1'b0;
      resp_err_q   <= 1'b0;
      wb_cyc_q     <= 1'b0;
      wb_stb_q     <= 1'b0;
      wb_we_q      <= 1'b0;
      wb_adr_q     <= '0;
      wb_dat_q     <= '0;
      wb_sel_q     <= '0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      timer_q      <= timer_d;
      cancel_q     <= cancel_d;
      resp_err_q   <= resp_err_d;
      wb_cyc_q     <= wb_cyc_d;
      wb_stb_q     <= wb_stb_d;
      wb_we_q      <= wb_we_d;
      wb_adr_q     <= wb_adr_d;
      wb_dat_q     <= wb_dat_d;
      wb_sel_q     <= wb_sel_d;
      rdata_q      <= rdata_d;
    end
  end

  assign ch_rdata_o = rdata_q;
  assign wb_cyc_o   = wb_cyc_q;
  assign wb_stb_o   = wb_stb_q;
  assign wb_we_o    = wb_we_q;
  assign wb_adr_o   = wb_adr_q;
  assign wb_dat_o   = wb_dat_q;
  assign wb_sel_o   = wb_sel_q;

endmodule

// File: tb/tb_wb_master_arbiter.sv
// Directed bench for wb_master_arbiter: a fixed-priority and a round-robin
// instance (both TIMEOUT=4) share the channel-side stimulus. The MMU model maps
// vaddr to paddr by clearing the top nibble.
module tb_wb_master_arbiter;

  localparam int NUM_CH = 2;
  localparam int DW     = 32;
  localparam int AW     = 32;

  logic                   clk;
  logic                   rst;
  logic [NUM_CH-1:0]      ch_req;
  logic [NUM_CH-1:0]      ch_we;
  logic [NUM_CH-1:0]      ch_cancel;
  logic [NUM_CH*AW-1:0]   ch_addr;
  logic [NUM_CH*DW-1:0]   ch_wdata;
  logic [NUM_CH*4-1:0]    ch_sel;
  logic                   xlat_fault;
  logic [DW-1:0]          wb_dat_in;
  logic                   man_ack;
  logic                   man_err;
  logic                   auto_ack;

  // Fixed-priority instance signals
  logic [DW-1:0] rdata_a;
  logic [1:0]    ack_a, err_a;
  logic          xreq_a, xwe_a;
  logic [AW-1:0] vaddr_a, paddr_a;
  logic          cyc_a, stb_a, we_a;
  logic [AW-1:0] adr_a;
  logic [DW-1:0] dat_a;
  logic [3:0]    sel_a;
  logic          wack_a;

  // Round-robin instance signals
  logic [DW-1:0] rdata_b;
  logic [1:0]    ack_b, err_b;
  logic          xreq_b, xwe_b;
  logic [AW-1:0] vaddr_b, paddr_b;
  logic          cyc_b, stb_b, we_b;
  logic [AW-1:0] adr_b;
  logic [DW-1:0] dat_b;
  logic [3:0]    sel_b;
  logic          wack_b;

  int n_checks;
  int n_fails;

  assign paddr_a = vaddr_a & 32'h0FFF_FFFF;
  assign paddr_b = vaddr_b & 32'h0FFF_FFFF;
  assign wack_a  = man_ack | (auto_ack & stb_a);
  assign wack_b  = man_ack | (auto_ack & stb_b);

  wb_master_arbiter #(.NUM_CH(2), .DW(32), .AW(32), .RR_MODE(0), .TIMEOUT(4)) dut_fp (
    .clk(clk), .rst(rst),
    .ch_req_i(ch_req), .ch_we_i(ch_we), .ch_cancel_i(ch_cancel),
    .ch_addr_i(ch_addr), .ch_wdata_i(ch_wdata), .ch_sel_i(ch_sel),
    .ch_rdata_o(rdata_a), .ch_ack_o(ack_a), .ch_err_o(err_a),
    .xlat_req_o(xreq_a), .xlat_we_o(xwe_a), .xlat_vaddr_o(vaddr_a),
    .xlat_paddr_i(paddr_a), .xlat_fault_i(xlat_fault),
    .wb_cyc_o(cyc_a), .wb_stb_o(stb_a), .wb_we_o(we_a),
    .wb_adr_o(adr_a), .wb_dat_o(dat_a), .wb_sel_o(sel_a),
    .wb_dat_i(wb_dat_in), .wb_ack_i(wack_a), .wb_err_i(man_err)
  );

  wb_master_arbiter #(.NUM_CH(2), .DW(32), .AW(32), .RR_MODE(1), .TIMEOUT(4)) dut_rr (
    .clk(clk), .rst(rst),
    .ch_req_i(ch_req), .ch_we_i(ch_we), .ch_cancel_i(ch_cancel),
    .ch_addr_i(ch_addr), .ch_wdata_i(ch_wdata), .ch_sel_i(ch_sel),
    .ch_rdata_o(rdata_b), .ch_ack_o(ack_b), .ch_err_o(err_b),
    .xlat_req_o(xreq_b), .xlat_we_o(xwe_b), .xlat_vaddr_o(vaddr_b),
    .xlat_paddr_i(paddr_b), .xlat_fault_i(xlat_fault),
    .wb_cyc_o(cyc_b), .wb_stb_o(stb_b), .wb_we_o(we_b),
    .wb_adr_o(adr_b), .wb_dat_o(dat_b), .wb_sel_o(sel_b),
    .wb_dat_i(wb_dat_in), .wb_ack_i(wack_b), .wb_err_i(man_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks   = 0;
    n_fails    = 0;
    rst        = 1'b0;
    ch_req     = 2'b00;
    ch_we      = 2'b00;
    ch_cancel  = 2'b00;
    ch_addr    = '0;
    ch_wdata   = '0;
    ch_sel     = '0;
    xlat_fault = 1'b0;
    wb_dat_in  = 32'h0;
    man_ack    = 1'b0;
    man_err    = 1'b0;
    auto_ack   = 1'b0;

    // Reset state
    tick;
    check("rst_cyc", 32'(cyc_a), 32'h0);
    check("rst_ack", 32'(ack_a), 32'h0);
    check("rst_err", 32'(err_a), 32'h0);
    check("rst_rdata", rdata_a, 32'h0);
    check("rst_xreq", 32'(xreq_a), 32'h0);
    rst = 1'b1;
    tick;

    // Single read on ch1, zero-wait slave
    ch_addr[63:32] = 32'h8000_0010;
    ch_req = 2'b10;
    #1;
    check("rd_xreq", 32'(xreq_a), 32'h1);
    check("rd_vaddr", vaddr_a, 32'h8000_0010);
    tick;
    check("rd_stb", 32'(stb_a), 32'h1);
    check("rd_adr", adr_a, 32'h0000_0010);
    check("rd_xreq_bus", 32'(xreq_a), 32'h0);
    man_ack   = 1'b1;
    wb_dat_in = 32'hDEAD_BEEF;
    tick;
    man_ack = 1'b0;
    check("rd_ack", 32'(ack_a), 32'h2);
    check("rd_rdata", rdata_a, 32'hDEAD_BEEF);
    check("rd_cyc_drop", 32'(cyc_a), 32'h0);
    ch_req = 2'b00;
    tick;
    check("rd_ack_done", 32'(ack_a), 32'h0);

    // Continuous requests on ch0 and ch1: fixed always ch0, RR alternates
    ch_addr[31:0]  = 32'h0000_0100;
    ch_addr[63:32] = 32'h0000_0200;
    wb_dat_in = 32'hCAFE_F00D;
    auto_ack  = 1'b1;
    ch_req    = 2'b11;
    for (int k = 0; k < 4; k++) begin
      tick;
      check("cont_adr_fp", adr_a, 32'h0000_0100);
      check("cont_adr_rr", adr_b, (k % 2 == 0) ? 32'h0000_0100 : 32'h0000_0200);
      tick;
      check("cont_ack_fp", 32'(ack_a), 32'h1);
      check("cont_ack_rr", 32'(ack_b), (k % 2 == 0) ? 32'h1 : 32'h2);
      check("cont_rdata", rdata_a, 32'hCAFE_F00D);
      if (k == 3) ch_req = 2'b00;
      tick;
      check("cont_idle_cyc", 32'(cyc_a), 32'h0);
    end
    auto_ack = 1'b0;

    // ack and err together: err wins, rdata cleared
    ch_req = 2'b01;
    tick;
    man_ack   = 1'b1;
    man_err   = 1'b1;
    wb_dat_in = 32'h5555_AAAA;
    tick;
    man_ack = 1'b0;
    man_err = 1'b0;
    check("ackerr_err", 32'(err_a), 32'h1);
    check("ackerr_ack", 32'(ack_a), 32'h0);
    check("ackerr_rdata", rdata_a, 32'h0);
    ch_req = 2'b00;
    tick;

    // Write on ch0 with two wait states
    ch_addr[31:0]  = 32'h0000_0300;
    ch_wdata[31:0] = 32'h1234_5678;
    ch_sel[3:0]    = 4'b0011;
    ch_we  = 2'b01;
    ch_req = 2'b01;
    tick;
    check("wr_adr", adr_a, 32'h0000_0300);
    check("wr_dat", dat_a, 32'h1234_5678);
    for (int c = 1; c <= 3; c++) begin
      check("wr_we", 32'(we_a), 32'h1);
      check("wr_sel", 32'(sel_a), 32'h3);
      if (c == 3) begin
        man_ack   = 1'b1;
        wb_dat_in = 32'hFFFF_FFFF;
      end
      tick;
    end
    man_ack = 1'b0;
    check("wr_ack", 32'(ack_a), 32'h1);
    check("wr_rdata", rdata_a, 32'h0);
    check("wr_we_drop", 32'(we_a), 32'h0);
    ch_req = 2'b00;
    ch_we  = 2'b00;
    tick;

    // Translation fault on ch1: immediate err, no bus cycle, last_grant moves
    ch_addr[63:32] = 32'h0000_0400;
    ch_req     = 2'b10;
    xlat_fault = 1'b1;
    #1;
    check("flt_xreq", 32'(xreq_a), 32'h1);
    check("flt_vaddr", vaddr_a, 32'h0000_0400);
    tick;
    xlat_fault = 1'b0;
    ch_req     = 2'b00;
    check("flt_err_fp", 32'(err_a), 32'h2);
    check("flt_err_rr", 32'(err_b), 32'h2);
    check("flt_cyc", 32'(cyc_a), 32'h0);
    tick;
    check("flt_cyc_idle", 32'(cyc_a), 32'h0);
    check("flt_err_done", 32'(err_a), 32'h0);
    ch_req = 2'b11;
    #1;
    check("flt_rr_next", vaddr_b, 32'h0000_0300);
    check("flt_fp_next", vaddr_a, 32'h0000_0300);
    ch_req = 2'b00;

    // Timeout: slave never answers
    ch_req = 2'b01;
    tick;
    for (int c = 1; c <= 4; c++) begin
      check("tmo_cyc_high", 32'(cyc_a), 32'h1);
      tick;
    end
    check("tmo_cyc_low", 32'(cyc_a), 32'h0);
    check("tmo_err_fp", 32'(err_a), 32'h1);
    check("tmo_err_rr", 32'(err_b), 32'h1);
    ch_req = 2'b00;
    tick;

    // Cancel pulsed mid-BUS: cycle completes, no response
    ch_req = 2'b01;
    tick;
    ch_cancel = 2'b01;
    tick;
    ch_cancel = 2'b00;
    check("cnl_cyc_held", 32'(cyc_a), 32'h1);
    man_ack = 1'b1;
    tick;
    man_ack = 1'b0;
    check("cnl_ack", 32'(ack_a), 32'h0);
    check("cnl_err", 32'(err_a), 32'h0);
    check("cnl_cyc_drop", 32'(cyc_a), 32'h0);
    ch_req = 2'b00;
    tick;

    // Asynchronous reset mid-BUS
    ch_req = 2'b01;
    tick;
    check("mrst_cyc_before", 32'(cyc_a), 32'h1);
    #2;
    rst = 1'b0;
    #1;
    check("mrst_cyc_fp", 32'(cyc_a), 32'h0);
    check("mrst_stb_fp", 32'(stb_a), 32'h0);
    check("mrst_cyc_rr", 32'(cyc_b), 32'h0);
    ch_req = 2'b00;
    tick;
    rst = 1'b1;
    tick;
    check("mrst_ack", 32'(ack_a), 32'h0);
    check("mrst_err", 32'(err_a), 32'h0);
    ch_req = 2'b11;
    #1;
    check("mrst_rr_lastgrant", vaddr_b, 32'h0000_0300);
    ch_req = 2'b00;
    tick;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/wb_master_arbiter.md
# wb_master_arbiter

Parametrised Wishbone master arbiter for the CPU core. It replaces the fixed two-port IF/MEM bus unit. NUM_CH requesters (IF, MEM, later a cache refill or debug port) share one Wishbone master port through fixed-priority or round-robin arbitration. Each granted address goes through the MMU in the grant cycle. Each transaction ends with a one-cycle per-channel ack or error pulse, and a bus timeout is built in.

## Interface
Parameters:
- NUM_CH, 2: number of requester channels (2..8); channel 0 is highest priority in fixed mode.
- DW, 32: data width; SELW = DW/8 derived.
- AW, 32: address width.
- RR_MODE, 0: 0 = fixed priority (lowest index wins); 1 = round-robin.
- TIMEOUT, 255: BUS-state cycles without ack/err before the transaction is aborted (1..65535).

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  reset; asynchronous, active-low.
- ch_req_i  in  NUM_CH  per-channel request level; held until that channel's ack/err.
- ch_we_i  in  NUM_CH  per-channel write enable.
- ch_cancel_i  in  NUM_CH  per-channel flush; suppresses the channel's response.
- ch_addr_i  in  NUM_CH*AW  virtual addresses, channel k at [k*AW +: AW].
- ch_wdata_i  in  NUM_CH*DW  write data, same packing.
- ch_sel_i  in  NUM_CH*SELW  byte selects, same packing.
- ch_rdata_o  out  DW  read data, shared, valid only with a ch_ack_o bit.
- ch_ack_o  out  NUM_CH  one-cycle completion pulse, one-hot.
- ch_err_o  out  NUM_CH  one-cycle error pulse, one-hot.
- xlat_req_o  out  1  translation request (combinational, IDLE with a winner).
- xlat_we_o  out  1  winner's write flag.
- xlat_vaddr_o  out  AW  winner's virtual address.
- xlat_paddr_i  in  AW  physical address, same cycle.
- xlat_fault_i  in  1  translation fault, same cycle.
- wb_cyc_o, wb_stb_o, wb_we_o  out  1  Wishbone control.
- wb_adr_o  out  AW; wb_dat_o  out  DW; wb_sel_o  out  SELW.
- wb_dat_i  in  DW; wb_ack_i  in  1; wb_err_i  in  1.

## Operation
- States:
  - IDLE: arbitrate.
  - BUS: cycle on Wishbone.
  - RESP: one-cycle response.
- IDLE:
  - Candidates are channels with ch_req_i=1 and ch_cancel_i=0.
  - Fixed mode: lowest index wins.
  - RR mode: first candidate strictly after last_grant, cyclic.
  - With a winner, xlat_* are driven from the winner's inputs.
  - If xlat_fault_i=1: go to RESP with err; no bus cycle is issued.
  - Otherwise: register wb_adr_o=xlat_paddr_i plus the winner's we/wdata/sel, set wb_cyc_o=wb_stb_o=1, store grant, clear timer, go to BUS.
  - last_grant updates on every grant, including faulted grants.
- BUS:
  - Outputs are held stable.
  - wb_ack_i: capture wb_dat_i (zero for writes) into ch_rdata_o; go to RESP with ack.
  - wb_err_i (takes priority over ack): ch_rdata_o=0; go to RESP with err.
  - Timer reaching TIMEOUT-1 with no ack/err: go to RESP with err.
  - Any exit drops wb_cyc_o/wb_stb_o/wb_we_o the same edge.
  - ch_cancel_i of the granted channel during BUS is latched. The bus cycle still completes, but the RESP pulse is suppressed.
- RESP:
  - Pulse ch_ack_o[g] or ch_err_o[g] unless cancel was latched (this cycle's ch_cancel_i[g] also suppresses).
  - Always return to IDLE.
- Requester sampling: a requester may keep ch_req_i high through its ack cycle to issue back-to-back; the new request is sampled in the following IDLE cycle.
- Reset (asynchronous, any state):
  - State=IDLE, last_grant=NUM_CH-1, all wb_* outputs 0, ch_ack_o=ch_err_o=0, ch_rdata_o=0, timer=0, cancel latch=0.
  - A mid-transaction reset drops wb_cyc_o immediately, with no response.

## Timing
- Zero-wait slave: request sampled cycle 0, wb_stb_o high cycle 1, wb_ack_i in cycle 1, ch_ack_o cycle 2, IDLE cycle 3. Minimum 3 cycles per transaction, next grant no earlier than cycle 3.
- A slave with n wait states adds n cycles.
- Fault path: request cycle 0, ch_err_o cycle 1, no wb_cyc_o.
- Timeout path: wb_cyc_o high for exactly TIMEOUT cycles, ch_err_o on the next cycle.
- xlat_* are purely combinational from ch_* in IDLE; in other states xlat_req_o=0.

## Test plan
- Single read, NUM_CH=2, ch1 addr 0x8000_0010, paddr 0x0000_0010, slave ack at cycle 1 with 0xDEADBEEF -> wb_adr_o=0x10 in cycle 1, ch_ack_o=2'b10 and ch_rdata_o=0xDEADBEEF in cycle 2.
- Fixed priority, ch0 and ch1 requesting continuously -> every grant goes to ch0. With RR_MODE=1 -> grants alternate 0,1,0,1 with one grant per 3 cycles.
- Write with sel=4'b0011, data 0x1234_5678, slave 2 wait states -> wb_we_o=1, wb_sel_o=0011 for 3 cycles, ch_ack_o at cycle 4, ch_rdata_o=0.
- xlat_fault_i=1 on grant -> ch_err_o pulse cycle 1, wb_cyc_o never high, last_grant advanced.
- TIMEOUT=4, slave never acks -> wb_cyc_o high cycles 1-4, ch_err_o cycle 5. wb_err_i and wb_ack_i together -> err wins.
- ch_cancel_i pulsed mid-BUS -> cycle completes, no ack/err pulse. rst asserted mid-BUS -> wb_cyc_o low asynchronously, state IDLE, no pulse.
